// File: rtl/nlp_btb.sv
// Next-line predictor: direct-mapped BTB with 2-bit bimodal counters, indexed by fetch PC.
// Returns per-slot hit/taken/target/counter for a 2-wide fetch group one cycle after lookup.

module nlp_btb_slot #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 10
) (
    input  logic [31:0]      pc,
    output logic [IDX_W-1:0] idx,
    input  logic             ent_valid,
    input  logic [TAG_W-1:0] ent_tag,
    input  logic [31:0]      ent_target,
    input  logic [1:0]       ent_bim,
    output logic             hit,
    output logic             taken,
    output logic [31:0]      target,
    output logic [1:0]       bim
);
    logic unused_pc;
    assign unused_pc = ^{pc[1:0], pc[31:IDX_W+2+TAG_W]};

    assign idx    = pc[IDX_W+1:2];
    assign hit    = ent_valid && (ent_tag == pc[IDX_W+2 +: TAG_W]);
    assign taken  = hit && ent_bim[1];
    assign target = hit ? ent_target : 32'd0;
    assign bim    = hit ? ent_bim : 2'b00;
endmodule

module nlp_btb #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp0_valid,
    output logic        resp0_taken,
    output logic [31:0] resp0_target,
    output logic [1:0]  resp0_bim,
    output logic        resp1_valid,
    output logic        resp1_taken,
    output logic [31:0] resp1_target,
    output logic [1:0]  resp1_bim,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_bim_state,
    input  logic        upd_should_take
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int SLOTS   = 2;

    logic [ENTRIES-1:0]            vld_mem;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_mem;
    logic [ENTRIES-1:0][31:0]      tgt_mem;
    logic [ENTRIES-1:0][1:0]       bim_mem;

    // Per-slot combinational read
    logic [SLOTS-1:0][IDX_W-1:0] rd_idx;
    logic [SLOTS-1:0]            rd_hit, rd_taken;
    logic [SLOTS-1:0][31:0]      rd_target;
    logic [SLOTS-1:0][1:0]       rd_bim;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        logic [31:0] slot_pc;
        assign slot_pc = lookup_pc + 32'(s) * 32'd4;

        nlp_btb_slot #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_slot (
            .pc         (slot_pc),
            .idx        (rd_idx[s]),
            .ent_valid  (vld_mem[rd_idx[s]]),
            .ent_tag    (tag_mem[rd_idx[s]]),
            .ent_target (tgt_mem[rd_idx[s]]),
            .ent_bim    (bim_mem[rd_idx[s]]),
            .hit        (rd_hit[s]),
            .taken      (rd_taken[s]),
            .target     (rd_target[s]),
            .bim        (rd_bim[s])
        );
    end

    // Response registers
    logic                   rv;
    logic [SLOTS-1:0]       rh, rt;
    logic [SLOTS-1:0][31:0] rtgt;
    logic [SLOTS-1:0][1:0]  rbim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv   <= 1'b0;
            rh   <= '0;
            rt   <= '0;
            rtgt <= '0;
            rbim <= '0;
        end else if (flush) begin
            rv   <= 1'b0;
            rh   <= '0;
            rt   <= '0;
            rtgt <= '0;
            rbim <= '0;
        end else if (!stall) begin
            rv   <= lookup_valid;
            rh   <= lookup_valid ? rd_hit    : '0;
            rt   <= lookup_valid ? rd_taken  : '0;
            rtgt <= lookup_valid ? rd_target : '0;
            rbim <= lookup_valid ? rd_bim    : '0;
        end
    end

    assign resp_valid   = rv;
    assign resp0_valid  = rh[0];
    assign resp0_taken  = rt[0];
    assign resp0_target = rtgt[0];
    assign resp0_bim    = rbim[0];
    assign resp1_valid  = rh[1];
    assign resp1_taken  = rt[1];
    assign resp1_target = rtgt[1];
    assign resp1_bim    = rbim[1];

    // Training: counter always derived from the snapshot carried with the prediction
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit, we_alloc, we_tgt, we_bim;
    logic [1:0]       new_bim;
    logic             unused_upd;

    assign unused_upd = ^{upd_pc[1:0], upd_pc[31:IDX_W+2+TAG_W]};
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign upd_tag    = upd_pc[IDX_W+2 +: TAG_W];
    assign upd_hit    = vld_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign we_alloc   = upd_valid && !upd_hit && upd_should_take;
    assign we_tgt     = upd_valid && upd_should_take;
    assign we_bim     = upd_valid && (upd_hit || upd_should_take);

    always_comb begin
        new_bim = upd_bim_state;
        if (upd_should_take) begin
            if (upd_bim_state != 2'b11) new_bim = upd_bim_state + 2'b01;
        end else begin
            if (upd_bim_state != 2'b00) new_bim = upd_bim_state - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           vld_mem <= '0;
        else if (we_alloc) vld_mem[upd_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we_alloc) tag_mem[upd_idx] <= upd_tag;
        if (we_tgt)   tgt_mem[upd_idx] <= upd_target;
        if (we_bim)   bim_mem[upd_idx] <= new_bim;
    end
endmodule

// File: tb/tb_nlp_btb.sv
// Directed bench for nlp_btb: hand-computed vectors checked with immediate assertions.

module tb_nlp_btb;
    logic        clk, rst;
    logic        lookup_valid, stall, flush;
    logic [31:0] lookup_pc;
    logic        resp_valid;
    logic        resp0_valid, resp0_taken, resp1_valid, resp1_taken;
    logic [31:0] resp0_target, resp1_target;
    logic [1:0]  resp0_bim, resp1_bim;
    logic        upd_valid, upd_should_take;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_bim_state;

    int n_checks = 0;
    int n_fail   = 0;

    nlp_btb dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .stall(stall), .flush(flush),
        .resp_valid(resp_valid),
        .resp0_valid(resp0_valid), .resp0_taken(resp0_taken),
        .resp0_target(resp0_target), .resp0_bim(resp0_bim),
        .resp1_valid(resp1_valid), .resp1_taken(resp1_taken),
        .resp1_target(resp1_target), .resp1_bim(resp1_bim),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_bim_state(upd_bim_state), .upd_should_take(upd_should_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one slot: {valid, taken, target, bim}
    task automatic chk_slot(input string tag, input int s, input logic v, input logic t,
                            input logic [31:0] tgt, input logic [1:0] b);
        if (s == 0) begin
            chk({tag, ".v0"},   32'(resp0_valid),  32'(v));
            chk({tag, ".t0"},   32'(resp0_taken),  32'(t));
            chk({tag, ".tgt0"}, resp0_target,      tgt);
            chk({tag, ".bim0"}, 32'(resp0_bim),    32'(b));
        end else begin
            chk({tag, ".v1"},   32'(resp1_valid),  32'(v));
            chk({tag, ".t1"},   32'(resp1_taken),  32'(t));
            chk({tag, ".tgt1"}, resp1_target,      tgt);
            chk({tag, ".bim1"}, 32'(resp1_bim),    32'(b));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [1:0] b, input logic take);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
        upd_bim_state = b; upd_should_take = take;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_valid = 1'b1; lookup_pc = pc;
        tick();
        lookup_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_bim_state = '0; upd_should_take = 1'b0;
        #12;
        chk("rst.resp_valid", 32'(resp_valid), 0);
        chk_slot("rst", 0, 0, 0, 0, 0);
        chk_slot("rst", 1, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: empty table lookup
        do_lookup(32'hBFC00000);
        chk("t1.resp_valid", 32'(resp_valid), 1);
        chk_slot("t1", 0, 0, 0, 0, 0);
        chk_slot("t1", 1, 0, 0, 0, 0);
        tick();
        chk("t1.idle", 32'(resp_valid), 0);

        // 2: allocate at idx 4 tag 0, hit on slot1
        do_upd(32'h80000010, 32'h80000100, 2'b01, 1'b1);
        do_lookup(32'h8000000C);
        chk_slot("t2", 0, 0, 0, 0, 0);
        chk_slot("t2", 1, 1, 1, 32'h80000100, 2'b10);

        // 3: saturation and decrement
        do_upd(32'h80000010, 32'h80000100, 2'b11, 1'b1);
        do_lookup(32'h80000010);
        chk_slot("t3sat", 0, 1, 1, 32'h80000100, 2'b11);
        do_upd(32'h80000010, 32'hDEADBEEF, 2'b11, 1'b0);
        do_upd(32'h80000010, 32'hDEADBEEF, 2'b10, 1'b0);
        do_lookup(32'h80000010);
        chk_slot("t3dec", 0, 1, 0, 32'h80000100, 2'b01);

        // 4: no allocate on not-taken miss; alias replacement
        do_upd(32'h80000200, 32'h80000300, 2'b01, 1'b0);
        do_lookup(32'h80000200);
        chk_slot("t4miss", 0, 0, 0, 0, 0);
        do_upd(32'h80000110, 32'h80000400, 2'b01, 1'b1);
        do_lookup(32'h80000010);
        chk_slot("t4old", 0, 0, 0, 0, 0);
        do_lookup(32'h80000110);
        chk_slot("t4new", 0, 1, 1, 32'h80000400, 2'b10);

        // 5: slot1 wraps index 63 -> 0, tag from pc+4
        do_upd(32'h80000100, 32'h80000800, 2'b10, 1'b1);
        do_lookup(32'h800000FC);
        chk_slot("t5", 0, 0, 0, 0, 0);
        chk_slot("t5", 1, 1, 1, 32'h80000800, 2'b11);

        // 6: stall holds, flush wins over stall
        do_lookup(32'h80000110);
        chk_slot("t6pre", 0, 1, 1, 32'h80000400, 2'b10);
        stall = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h800000FC;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6stall.rv", 32'(resp_valid), 1);
            chk("t6stall.tgt0", resp0_target, 32'h80000400);
            chk("t6stall.v1", 32'(resp1_valid), 0);
        end
        flush = 1'b1;
        tick();
        chk("t6flush.rv", 32'(resp_valid), 0);
        chk("t6flush.v0", 32'(resp0_valid), 0);
        flush = 1'b0; stall = 1'b0; lookup_valid = 1'b0;

        // Same-cycle update + lookup to same index returns old contents
        upd_valid = 1'b1; upd_pc = 32'h80000110; upd_target = 32'h80000900;
        upd_bim_state = 2'b11; upd_should_take = 1'b1;
        do_lookup(32'h80000110);
        upd_valid = 1'b0;
        chk_slot("t6byp", 0, 1, 1, 32'h80000400, 2'b10);
        do_lookup(32'h80000110);
        chk_slot("t6post", 0, 1, 1, 32'h80000900, 2'b11);

        // Reset mid-operation clears the table
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        chk("rst2.rv", 32'(resp_valid), 0);
        @(negedge clk);
        do_lookup(32'h80000110);
        chk("rst2.rv1", 32'(resp_valid), 1);
        chk_slot("rst2", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
